// File: rtl/blc_pkg.sv
// Shared constants for the black-level correction pipeline.
package blc_pkg;

  localparam logic [1:0] BLC_MODE_BYPASS = 2'd0;
  localparam logic [1:0] BLC_MODE_CLAMP  = 2'd1;
  localparam logic [1:0] BLC_MODE_WRAP   = 2'd2;

  localparam int BLC_STAGES = 3;

  // Encoding 3 is an alias of CLAMP; fold it once at capture time.
  function automatic logic [1:0] blc_norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? BLC_MODE_CLAMP : m;
  endfunction

endpackage

// File: rtl/blc_lane.sv
// One colour channel: S2 difference register, S3 mode application and output register.
module blc_lane import blc_pkg::*; #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic [DATA_WIDTH-1:0] s1_offset,
  input  logic [1:0]            s2_mode,
  output logic                  clip,
  output logic [DATA_WIDTH-1:0] data_out
);

  // MSB of the extended difference is the borrow, i.e. the sign of d - o.
  logic [DATA_WIDTH:0]   s2_diff;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [DATA_WIDTH-1:0] res;

  // S2 difference and S3 result registers, moving in lockstep with the valid pipe
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_diff  <= '0;
      s2_data  <= '0;
      data_out <= '0;
    end else if (advance) begin
      s2_diff  <= {1'b0, s1_data} - {1'b0, s1_offset};
      s2_data  <= s1_data;
      data_out <= res;
    end
  end

  // Apply the correction mode to the S2 difference
  always_comb begin
    res  = s2_diff[DATA_WIDTH-1:0];
    clip = 1'b0;
    case (s2_mode)
      BLC_MODE_BYPASS: res = s2_data;
      BLC_MODE_WRAP:   res = s2_diff[DATA_WIDTH-1:0];
      default: begin
        clip = s2_diff[DATA_WIDTH];
        res  = clip ? '0 : s2_diff[DATA_WIDTH-1:0];
      end
    endcase
  end

endmodule

// File: rtl/blc_pipe.sv
// Three-stage black-level correction pipeline with valid/ready flow control
// and a saturating count of clamped samples.
module blc_pipe import blc_pkg::*; #(
  parameter int DATA_WIDTH = 12,
  parameter int CHANNELS   = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           u_i_ready,
  output logic                           i_i_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] aux_in,
  input  logic                           u_r_ready,
  output logic                           i_r_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic [CHANNELS*DATA_WIDTH-1:0] aux_out,
  input  logic                           cfg_we,
  input  logic [CHANNELS*DATA_WIDTH-1:0] cfg_offset,
  input  logic [1:0]                     cfg_mode,
  input  logic                           clear_stats,
  output logic [CNT_WIDTH-1:0]           clip_count
);

  localparam int NW = $clog2(CHANNELS + 1);
  localparam int SW = CNT_WIDTH + NW;

  logic [BLC_STAGES:1]                   vld_pipe;
  logic                                  advance;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]   offset_q;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]   s1_data;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]   s1_offset;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]   lane_out;
  logic [CHANNELS*DATA_WIDTH-1:0]        s1_aux;
  logic [CHANNELS*DATA_WIDTH-1:0]        s2_aux;
  logic [1:0]                            s1_mode;
  logic [1:0]                            s2_mode;
  logic [CHANNELS-1:0]                   clip;
  logic [NW-1:0]                         n_clip;
  logic [SW-1:0]                         cnt_sum;

  // The whole pipe moves together; only a full, blocked S3 stops it.
  assign advance   = !vld_pipe[BLC_STAGES] || u_r_ready;
  assign i_i_ready = advance;
  assign i_r_ready = vld_pipe[BLC_STAGES];
  assign data_out  = lane_out;

  // Offset register; a beat accepted on the write cycle still sees the old value
  always_ff @(posedge clock) begin
    if (reset)       offset_q <= '0;
    else if (cfg_we) offset_q <= cfg_offset;
  end

  // Valid shift register; empty slots shift along like beats
  always_ff @(posedge clock) begin
    if (reset)        vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[BLC_STAGES-1:1], u_i_ready};
  end

  // S1 capture plus the aux/mode sideband travelling alongside the lanes
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_data   <= '0;
      s1_offset <= '0;
      s1_aux    <= '0;
      s1_mode   <= '0;
      s2_aux    <= '0;
      s2_mode   <= '0;
      aux_out   <= '0;
    end else if (advance) begin
      s1_data   <= data_in;
      s1_offset <= offset_q;
      s1_aux    <= aux_in;
      s1_mode   <= blc_norm_mode(cfg_mode);
      s2_aux    <= s1_aux;
      s2_mode   <= s1_mode;
      aux_out   <= s2_aux;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    blc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clock     (clock),
      .reset     (reset),
      .advance   (advance),
      .s1_data   (s1_data[c]),
      .s1_offset (s1_offset[c]),
      .s2_mode   (s2_mode),
      .clip      (clip[c]),
      .data_out  (lane_out[c])
    );
  end

  // Number of channels clamped in the beat currently in S2
  always_comb begin
    n_clip = '0;
    for (int c = 0; c < CHANNELS; c++) n_clip = n_clip + NW'(clip[c]);
  end

  assign cnt_sum = SW'(clip_count) + SW'(n_clip);

  // Saturating clip counter, bumped as a valid beat moves S2 -> S3; clear wins
  always_ff @(posedge clock) begin
    if (reset || clear_stats) begin
      clip_count <= '0;
    end else if (advance && vld_pipe[BLC_STAGES-1]) begin
      if (|cnt_sum[SW-1:CNT_WIDTH]) clip_count <= '1;
      else                          clip_count <= cnt_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_blc_pipe.sv
// Self-checking bench for blc_pipe: directed vector table, hand-written
// corner sequences and a randomized stream against a scoreboard model.
module tb_blc_pipe;

  localparam int DW = 12;
  localparam int CH = 3;
  localparam int CW = 4;
  localparam int W  = DW * CH;
  localparam int CLIP_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          u_i_ready = 1'b0;
  logic          i_i_ready;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  aux_in = '0;
  logic          u_r_ready = 1'b0;
  logic          i_r_ready;
  logic [W-1:0]  data_out;
  logic [W-1:0]  aux_out;
  logic          cfg_we = 1'b0;
  logic [W-1:0]  cfg_offset = '0;
  logic [1:0]    cfg_mode = 2'd0;
  logic          clear_stats = 1'b0;
  logic [CW-1:0] clip_count;

  blc_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .u_i_ready(u_i_ready), .i_i_ready(i_i_ready),
    .data_in(data_in), .aux_in(aux_in),
    .u_r_ready(u_r_ready), .i_r_ready(i_r_ready),
    .data_out(data_out), .aux_out(aux_out),
    .cfg_we(cfg_we), .cfg_offset(cfg_offset), .cfg_mode(cfg_mode),
    .clear_stats(clear_stats), .clip_count(clip_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: per-channel arithmetic straight from the mode definitions
  function automatic logic [W-1:0] ref_out(input logic [1:0] m, input logic [W-1:0] d,
                                           input logic [W-1:0] o);
    logic [W-1:0] r;
    int dv, ov, rv;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      dv = int'(d[c*DW +: DW]);
      ov = int'(o[c*DW +: DW]);
      if (m == 2'd0)      rv = dv;
      else if (m == 2'd2) rv = (dv - ov + (1 << DW)) % (1 << DW);
      else                rv = (dv >= ov) ? dv - ov : 0;
      r[c*DW +: DW] = DW'(rv);
    end
    return r;
  endfunction

  function automatic int ref_nclip(input logic [1:0] m, input logic [W-1:0] d,
                                   input logic [W-1:0] o);
    int n;
    n = 0;
    if (m == 2'd1 || m == 2'd3)
      for (int c = 0; c < CH; c++)
        if (d[c*DW +: DW] < o[c*DW +: DW]) n++;
    return n;
  endfunction

  // Scoreboard: expected beats queued at acceptance, compared at delivery
  typedef struct packed { logic [W-1:0] d; logic [W-1:0] a; } beat_t;
  beat_t        exp_q[$];
  beat_t        bt;
  logic [W-1:0] off_m = '0;
  int           clip_m = 0;
  int           n_out = 0;
  int           stall_seen = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] dprev = '0;
  logic [W-1:0] aprev = '0;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      off_m = '0;
      clip_m = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_data", data_out, dprev);
        chk("hold_aux", aux_out, aprev);
      end
      if (i_r_ready && !u_r_ready) begin
        chk("stall_i_i_ready", i_i_ready, 0);
        stall_seen++;
      end
      stall_prev = i_r_ready && !u_r_ready;
      dprev = data_out;
      aprev = aux_out;
      if (i_r_ready && u_r_ready) begin
        n_out++;
        chk("sb_beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          bt = exp_q.pop_front();
          chk("sb_data", data_out, bt.d);
          chk("sb_aux", aux_out, bt.a);
        end
      end
      if (u_i_ready && i_i_ready) begin
        exp_q.push_back({ref_out(cfg_mode, data_in, off_m), aux_in});
        clip_m = clip_m + ref_nclip(cfg_mode, data_in, off_m);
        if (clip_m > CLIP_MAX) clip_m = CLIP_MAX;
      end
      if (cfg_we) off_m = cfg_offset;
      if (clear_stats) clip_m = 0;
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] a, input logic [1:0] m);
    int n;
    n = 0;
    u_i_ready = 1'b1; data_in = d; aux_in = a; cfg_mode = m;
    @(negedge clock);
    while (!i_i_ready && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) chk("send_timeout", i_i_ready, 1);
    @(posedge clock); #1;
    u_i_ready = 1'b0;
  endtask

  task automatic drain(input string nm);
    u_i_ready = 1'b0; u_r_ready = 1'b1; cfg_we = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk(nm, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] d;
    logic [W-1:0] o;
    logic [W-1:0] a;
    logic [W-1:0] e;
    int           nc;
  } vec_t;
  vec_t vt[8];

  logic [W-1:0] rnd_off;
  int n0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'd1, {3{12'h100}}, {3{12'h040}}, 36'h123456789, {3{12'h0C0}}, 0};
    vt[1] = '{2'd1, {12'h020, 12'h100, 12'h010}, {3{12'h040}}, 36'hABCDEF012,
              {12'h000, 12'h0C0, 12'h000}, 2};
    vt[2] = '{2'd2, {12'h020, 12'h100, 12'h010}, {3{12'h040}}, 36'hFEDCBA987,
              {12'hFE0, 12'h0C0, 12'hFD0}, 0};
    vt[3] = '{2'd0, {12'h020, 12'h100, 12'h010}, {3{12'h040}}, 36'h000000001,
              {12'h020, 12'h100, 12'h010}, 0};
    vt[4] = '{2'd3, {12'h020, 12'h100, 12'h010}, {3{12'h040}}, 36'h800000000,
              {12'h000, 12'h0C0, 12'h000}, 2};
    vt[5] = '{2'd1, {12'h123, 12'h455, 12'h78A}, {12'h123, 12'h456, 12'h789}, 36'h5A5A5A5A5,
              {12'h000, 12'h000, 12'h001}, 1};
    vt[6] = '{2'd2, {12'h000, 12'hFFF, 12'h800}, {12'hFFF, 12'h000, 12'h801}, 36'hA5A5A5A5A,
              {12'h001, 12'hFFF, 12'hFFF}, 0};
    vt[7] = '{2'd1, {12'hFFF, 12'h000, 12'hFFF}, {12'h000, 12'h001, 12'hFFE}, 36'hFFFFFFFFF,
              {12'hFFF, 12'h000, 12'h001}, 1};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_i_r_ready", i_r_ready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_aux_out", aux_out, 0);
    chk("rst_clip_count", clip_count, 0);
    chk("rst_i_i_ready", i_i_ready, 1);
    reset = 1'b0;
    u_r_ready = 1'b1;
    @(posedge clock); #1;

    // Vector table: one isolated beat each, latency and counter delta checked
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_offset = vt[i].o; clear_stats = 1'b1;
      @(posedge clock); #1;
      cfg_we = 1'b0; clear_stats = 1'b0;
      u_i_ready = 1'b1; data_in = vt[i].d; aux_in = vt[i].a; cfg_mode = vt[i].m;
      @(posedge clock); #1;
      u_i_ready = 1'b0;
      @(posedge clock); #1;
      chk($sformatf("v%0d_not_yet_valid", i), i_r_ready, 0);
      @(posedge clock); #1;
      chk($sformatf("v%0d_valid", i), i_r_ready, 1);
      chk($sformatf("v%0d_data", i), data_out, vt[i].e);
      chk($sformatf("v%0d_aux", i), aux_out, vt[i].a);
      chk($sformatf("v%0d_clip", i), clip_count, vt[i].nc);
      @(posedge clock); #1;
      chk($sformatf("v%0d_gone", i), i_r_ready, 0);
    end

    // Offset write in the same cycle a beat is accepted
    cfg_we = 1'b1; cfg_offset = {3{12'h040}};
    @(posedge clock); #1;
    u_i_ready = 1'b1; data_in = {3{12'h100}}; aux_in = 36'h1; cfg_mode = 2'd1;
    cfg_offset = {3{12'h010}};
    @(posedge clock); #1;
    cfg_we = 1'b0; aux_in = 36'h2;
    @(posedge clock); #1;
    u_i_ready = 1'b0;
    @(posedge clock); #1;
    chk("cfg_b1_valid", i_r_ready, 1);
    chk("cfg_b1_old_offset", data_out, {3{12'h0C0}});
    chk("cfg_b1_aux", aux_out, 36'h1);
    @(posedge clock); #1;
    chk("cfg_b2_valid", i_r_ready, 1);
    chk("cfg_b2_new_offset", data_out, {3{12'h0F0}});
    chk("cfg_b2_aux", aux_out, 36'h2);
    drain("cfg_drain");

    // Ten-beat stream with the sink stalled for cycles 4..8
    n0 = n_out;
    stall_seen = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) send({3{12'(k * 16 + 5)}}, W'(k + 100), 2'd2);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          u_r_ready = !(c >= 4 && c <= 8);
          @(posedge clock); #1;
        end
      end
    join
    drain("stream_drain");
    chk("stream_count", n_out - n0, 10);
    chk("stream_stall_seen", stall_seen > 0, 1);

    // Clip counter saturation at 2^CNT_WIDTH-1
    cfg_we = 1'b1; cfg_offset = {3{12'h800}}; clear_stats = 1'b1;
    @(posedge clock); #1;
    cfg_we = 1'b0; clear_stats = 1'b0;
    for (int k = 0; k < 4; k++) send({3{12'h100}}, W'(k), 2'd1);
    drain("sat_drain1");
    chk("sat_12", clip_count, 12);
    send({3{12'h100}}, 36'h5, 2'd1);
    drain("sat_drain2");
    chk("sat_15", clip_count, 15);
    send({3{12'h100}}, 36'h6, 2'd1);
    send({3{12'h100}}, 36'h7, 2'd1);
    drain("sat_drain3");
    chk("sat_hold", clip_count, 15);
    // clear_stats on the very edge a clamped beat moves S2 -> S3
    send({3{12'h100}}, 36'h8, 2'd1);
    @(posedge clock); #1;
    clear_stats = 1'b1;
    @(posedge clock); #1;
    clear_stats = 1'b0;
    chk("clear_priority", clip_count, 0);
    drain("clear_drain");
    chk("clear_stays_0", clip_count, 0);

    // Reset with three beats in flight
    u_r_ready = 1'b0;
    for (int k = 0; k < 3; k++) send({3{12'h555}}, W'(36'h777 + k), 2'd0);
    chk("flight_s3_full", i_r_ready, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_i_r_ready", i_r_ready, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_aux_out", aux_out, 0);
    reset = 1'b0;
    chk("post_rst_i_i_ready", i_i_ready, 1);
    u_r_ready = 1'b1;
    n0 = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (i_r_ready) n0++;
    end
    chk("post_rst_no_stale", n0, 0);

    // Randomized traffic in chunks, counter checked once each chunk drains
    for (int ch = 0; ch < 4; ch++) begin
      clear_stats = 1'b1;
      @(posedge clock); #1;
      clear_stats = 1'b0;
      for (int c = 0; c < 60; c++) begin
        for (int k = 0; k < CH; k++) rnd_off[k*DW +: DW] = DW'($urandom_range(0, 511));
        u_i_ready   = ($urandom_range(0, 3) != 0);
        data_in     = W'({$urandom, $urandom});
        aux_in      = W'({$urandom, $urandom});
        cfg_mode    = 2'($urandom_range(0, 3));
        cfg_we      = ($urandom_range(0, 7) == 0);
        cfg_offset  = rnd_off;
        u_r_ready   = ($urandom_range(0, 3) != 0);
        @(posedge clock); #1;
      end
      drain($sformatf("rnd%0d_drain", ch));
      chk($sformatf("rnd%0d_clip", ch), clip_count, clip_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blc_pipe.md
BLC_PIPE -- requirements
Module: blc_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 12, bits per colour sample.
REQ-002 Parameter CHANNELS, default 3, samples per beat (packed channel 0 in LSBs).
REQ-003 Parameter CNT_WIDTH, default 16, width of the clip statistics counter.
REQ-004 Port clock input 1, single clock; all logic rising-edge.
REQ-005 Port reset input 1, synchronous active-high reset.
REQ-006 Port u_i_ready input 1, upstream has a valid beat on data_in/aux_in.
REQ-007 Port i_i_ready output 1, block can accept a beat this cycle.
REQ-008 Port data_in input CHANNELS*DATA_WIDTH, raw samples.
REQ-009 Port aux_in input CHANNELS*DATA_WIDTH, sideband carried unchanged.
REQ-010 Port u_r_ready input 1, downstream accepts the output beat this cycle.
REQ-011 Port i_r_ready output 1, data_out/aux_out hold a valid beat.
REQ-012 Port data_out output CHANNELS*DATA_WIDTH, corrected samples.
REQ-013 Port aux_out output CHANNELS*DATA_WIDTH, aux aligned with data_out.
REQ-014 Port cfg_we input 1, load cfg_offset into the offset register.
REQ-015 Port cfg_offset input CHANNELS*DATA_WIDTH, unsigned per-channel black level.
REQ-016 Port cfg_mode input 2, correction mode (BYPASS=0, CLAMP=1, WRAP=2, 3 treated as CLAMP).
REQ-017 Port clear_stats input 1, zero clip_count.
REQ-018 Port clip_count output CNT_WIDTH, saturating count of clamped channel samples.

Function
REQ-019 Accept a beat when u_i_ready && i_i_ready; deliver it when i_r_ready && u_r_ready.
REQ-020 Datapath: 3 registered stages, each with a valid bit: S1 capture data, aux, offset, mode; S2 compute d - o at DATA_WIDTH+1 bits signed; S3 apply mode and hold output.
REQ-021 Latency: beat accepted in cycle N appears with i_r_ready=1 in cycle N+3 when not stalled; throughput 1 beat/cycle.
REQ-022 Stall: advance = !S3_valid || u_r_ready; when advance=0, all stages hold contents; when advance=1, all stages shift, including empty ones (bubbles collapse only at S3).
REQ-023 i_i_ready = advance (combinational from S3_valid, u_r_ready); no beat lost or duplicated under any u_r_ready pattern.
REQ-024 i_r_ready = S3_valid; data_out/aux_out remain stable while i_r_ready && !u_r_ready.
REQ-025 BYPASS: data_out = data_in, unchanged.
REQ-026 CLAMP: per channel, data_out = d - o if d >= o, else 0.
REQ-027 WRAP: per channel, data_out = (d - o) mod 2^DATA_WIDTH.
REQ-028 Mode and offset are sampled into S1 with each beat; cfg changes never affect beats already accepted.
REQ-029 cfg_we in cycle N: offset register updated at end of cycle N; beats accepted in N+1 onward use new value; beat accepted in cycle N uses old value.
REQ-030 clip_count increments by the number of channels clamped (d < o, CLAMP mode) in the beat leaving S2 into S3, saturating at 2^CNT_WIDTH-1.
REQ-031 clear_stats has priority over a simultaneous increment; count is 0 the following cycle.
REQ-032 aux_out equals the aux_in captured with the same beat, bit-exact, in all modes.

Reset
REQ-033 Reset clears all stage valid bits, data_out, aux_out, offset register and clip_count to 0; i_r_ready=0.
REQ-034 Reset mid-stream discards in-flight beats; i_i_ready=1 in the first cycle after reset deasserts.

Structure
REQ-035 Shared package blc_pkg holds mode encodings (BLC_MODE_BYPASS/CLAMP/WRAP) and the stage-count constant BLC_STAGES=3.
REQ-036 Sub-module blc_lane implements one channel's subtract/clamp/wrap and clip flag; instantiated CHANNELS times via generate.

Verification
REQ-037 CLAMP, offset 0x040 all channels, data 0x100 -> data_out 0x0C0 each channel, 3 cycles later, clip_count unchanged.
REQ-038 CLAMP, data {0x020,0x100,0x010}, offset 0x040 -> data_out {0x000,0x0C0,0x000}, clip_count +2; same in WRAP -> {0xFE0,0x0C0,0xFD0}, no increment.
REQ-039 Continuous stream of 10 incrementing beats, u_r_ready low for cycles 4-8 -> i_i_ready low while S3 full and stalled, all 10 beats out in order with matching aux.
REQ-040 cfg_we changing offset 0x040->0x010 in the same cycle a beat is accepted -> that beat uses 0x040, next beat uses 0x010.
REQ-041 CNT_WIDTH=4, 20 clamped channel samples -> clip_count stops at 15; clear_stats with simultaneous clip -> 0.
REQ-042 Reset asserted with 3 beats in flight -> i_r_ready=0, outputs 0 next cycle, no stale beat emitted after release.
